// File: rtl/dr_channel_arbiter.sv
// Two-requester round-robin arbiter driving one dual-rail token at a time into an async pipeline.
// Latency: grant 1 cycle after req; each ack edge costs SYNC_STAGES+1 cycles; req->done >= 2*SYNC_STAGES+3.
// Backpressure: the 4-phase ack handshake paces tokens; a stalled ack beyond TIMEOUT cycles parks the block in ERR.
module dr_channel_arbiter #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       bit0,
  output logic       done0,
  input  logic       req1,
  input  logic       bit1,
  output logic       done1,
  output logic [1:0] data_out,
  input  logic       ack_in,
  output logic       busy,
  output logic       err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DATA = 3'd1,
    ST_NULL = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic                   ack_s;
  logic [CNT_W-1:0]       wait_cnt_q, wait_cnt_d;
  logic                   gnt_q, gnt_d;     // index of the requester owning the token in flight
  logic                   bit_q, bit_d;     // bit value of the token in flight
  logic                   last_q, last_d;   // requester granted most recently
  logic [1:0]             data_out_q, data_out_d;
  logic                   done0_q, done0_d;
  logic                   done1_q, done1_d;
  logic                   busy_q, busy_d;
  logic                   err_q, err_d;
  logic                   any_req;
  logic                   pick;

  // Bring the asynchronous acknowledge into the clock domain; only the last flop is used.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_sync_q <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_in};
    end
  end

  assign ack_s = ack_sync_q[SYNC_STAGES-1];

  // Round-robin choice: on contention the requester that did not win last time goes first.
  always_comb begin
    any_req = req0 | req1;
    pick    = 1'b0;
    if (req0 && req1) begin
      pick = ~last_q;
    end else if (req1) begin
      pick = 1'b1;
    end
  end

  // Next-state logic for the 4-phase handshake, plus the registered-output next values.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    gnt_d      = gnt_q;
    bit_d      = bit_q;
    last_d     = last_q;

    case (state_q)
      ST_IDLE: begin
        // Wait for the pipeline head to drain (ack low) before launching a new token.
        if (any_req && !ack_s) begin
          gnt_d      = pick;
          bit_d      = pick ? bit1 : bit0;
          wait_cnt_d = '0;
          state_d    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (ack_s) begin
          wait_cnt_d = '0;
          state_d    = ST_NULL;
        end else if (wait_cnt_q == CNT_MAX) begin
          state_d = ST_ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_NULL: begin
        if (!ack_s) begin
          state_d = ST_DONE;
        end else if (wait_cnt_q == CNT_MAX) begin
          state_d = ST_ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        last_d  = gnt_q;
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are computed from the next state so every output pin comes straight from a flop.
    data_out_d = (state_d == ST_DATA) ? {bit_d, ~bit_d} : 2'b00;
    done0_d    = (state_d == ST_DONE) && !gnt_d;
    done1_d    = (state_d == ST_DONE) &&  gnt_d;
    busy_d     = (state_d != ST_IDLE);
    err_d      = (state_d == ST_ERR);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      gnt_q      <= 1'b0;
      bit_q      <= 1'b0;
      last_q     <= 1'b1;
      data_out_q <= 2'b00;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      gnt_q      <= gnt_d;
      bit_q      <= bit_d;
      last_q     <= last_d;
      data_out_q <= data_out_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign data_out = data_out_q;
  assign done0    = done0_q;
  assign done1    = done1_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule

// File: tb/tb_dr_channel_arbiter.sv
// Bench for dr_channel_arbiter: directed handshake scenarios plus random two-requester traffic.
// A 3-stage dual-rail pipeline model supplies ack; a monitor scoreboards every done pulse.
// Expected token bits are queued by stimulus and popped by the monitor and the pipeline sink.
module tb_dr_channel_arbiter;

  localparam int SYNC = 2;
  localparam int TO   = 40;

  logic       clk = 1'b0;
  logic       rst, req0, bit0, req1, bit1, ack_in;
  logic       done0, done1, busy, err;
  logic [1:0] data_out;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  // pipeline model state
  logic [1:0] stg0, stg1, stg2, cons, dout_prev;
  bit         ack_mode;     // 1: ack_in forced to ack_force
  bit         pipe_stall;   // 1: stages advance randomly
  logic       ack_force;

  // scoreboard queues
  bit gq[$];                // bits launched onto data_out, in order
  bit eq0[$], eq1[$];       // bits each requester expects to be delivered

  // monitor model state
  logic [1:0] m_prev;
  logic       m_r0, m_r1;
  int         m_nd, m_nn, m_exp;
  bit         m_last, m_bit;

  dr_channel_arbiter #(.SYNC_STAGES(SYNC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .bit0(bit0), .done0(done0),
    .req1(req1), .bit1(bit1), .done1(done1),
    .data_out(data_out), .ack_in(ack_in), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vec_cnt++;
    if (act != exp) begin
      miss_cnt++;
      $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input int info);
    vec_cnt++;
    miss_cnt++;
    $display("FAIL %s: expected event missing (info %0d) at %0t", name, info, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [1:0] stage_nx(logic [1:0] cur, logic [1:0] din, logic [1:0] nxt);
    if (din != 2'b00 && nxt == 2'b00) return din;
    if (din == 2'b00 && nxt != 2'b00) return 2'b00;
    return cur;
  endfunction

  function automatic bit stage_en();
    return !pipe_stall || ($urandom_range(0, 3) != 0);
  endfunction

  // Dual-rail C-element pipeline (3 stages + sink); head stage reacts one cycle after data_out changes.
  initial begin : pipe_model
    logic       rs;
    logic [1:0] n0, n1, n2, nc;
    stg0 = 2'b00; stg1 = 2'b00; stg2 = 2'b00; cons = 2'b00; dout_prev = 2'b00;
    ack_in = 1'b0;
    forever begin
      @(posedge clk);
      rs = rst;
      #1;
      if (rs) begin
        stg0 = 2'b00; stg1 = 2'b00; stg2 = 2'b00; cons = 2'b00;
      end else begin
        n0 = stage_en() ? stage_nx(stg0, dout_prev, stg1) : stg0;
        n1 = stage_en() ? stage_nx(stg1, stg0, stg2) : stg1;
        n2 = stage_en() ? stage_nx(stg2, stg1, cons) : stg2;
        nc = cons;
        if (stage_en()) begin
          if (cons == 2'b00 && stg2 != 2'b00) nc = stg2;
          else if (cons != 2'b00 && stg2 == 2'b00) nc = 2'b00;
        end
        if (cons == 2'b00 && nc != 2'b00) begin
          chk("sink_codeword_legal", int'(nc == 2'b11), 0);
          if (gq.size() == 0) fail_now("sink_unexpected_token", nc);
          else chk("delivered_bit", nc[1], gq.pop_front());
        end
        stg0 = n0; stg1 = n1; stg2 = n2; cons = nc;
      end
      dout_prev = data_out;
      ack_in = ack_mode ? ack_force : (stg0 != 2'b00);
    end
  end

  // Scoreboard monitor: tracks DATA/NULL phases and the round-robin expectation, checks each done.
  initial begin : monitor
    int k;
    m_prev = 2'b00; m_r0 = 1'b0; m_r1 = 1'b0; m_nd = 0; m_nn = 0; m_last = 1'b1; m_exp = -1; m_bit = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        gq.delete(); eq0.delete(); eq1.delete();
        m_nd = 0; m_nn = 0; m_last = 1'b1; m_exp = -1;
      end else begin
        chk("codeword_legal", int'(data_out == 2'b11), 0);
        if (m_prev == 2'b00 && data_out != 2'b00) begin
          m_nd++;
          m_bit = data_out[1];
          if (m_r0 && m_r1) m_exp = m_last ? 0 : 1;
          else if (m_r0) m_exp = 0;
          else if (m_r1) m_exp = 1;
          else m_exp = -1;
          gq.push_back(m_bit);
        end else if (m_prev != 2'b00 && data_out == 2'b00) begin
          m_nn++;
        end else if (m_prev != 2'b00 && data_out != m_prev) begin
          chk("codeword_stable", data_out, m_prev);
        end
        if (done0 || done1) begin
          chk("done_exclusive", int'(done0 && done1), 0);
          k = done1 ? 1 : 0;
          chk("grant_order", k, m_exp);
          chk("data_phases", m_nd, 1);
          chk("null_phases", m_nn, 1);
          if (k == 0) begin
            if (eq0.size() == 0) fail_now("done0_unexpected", 0);
            else chk("token_bit0", m_bit, eq0.pop_front());
          end else begin
            if (eq1.size() == 0) fail_now("done1_unexpected", 1);
            else chk("token_bit1", m_bit, eq1.pop_front());
          end
          m_last = (k == 1);
          m_nd = 0; m_nn = 0; m_exp = -1;
        end
      end
      m_prev = data_out;
      m_r0 = req0;
      m_r1 = req1;
    end
  end

  task automatic drive(input int k, input int ntok);
    int tok, w;
    bit b, hold, got;
    tok = 0; hold = 1'b0; b = 1'b0;
    while (tok < ntok) begin
      if (!hold) begin
        repeat ($urandom_range(1, 4)) tick();
        b = 1'($urandom_range(0, 1));
        if (k == 0) begin eq0.push_back(b); bit0 = b; req0 = 1'b1; end
        else        begin eq1.push_back(b); bit1 = b; req1 = 1'b1; end
      end else begin
        if (k == 0) eq0.push_back(b);
        else        eq1.push_back(b);
      end
      w = 0; got = 1'b0;
      do begin
        tick();
        w++;
        got = (k == 0) ? done0 : done1;
      end while (!got && w < 400);
      if (!got) begin
        fail_now("rand_done_timeout", k);
        if (k == 0) req0 = 1'b0; else req1 = 1'b0;
        return;
      end
      tok++;
      hold = (tok < ntok) && ($urandom_range(0, 1) == 1);
      if (!hold) begin
        if (k == 0) req0 = 1'b0; else req1 = 1'b0;
      end
    end
  endtask

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int  n, cnt, cw;
    bit  got, saw, stay, b;
    int  dlog[$];
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; bit0 = 1'b0; bit1 = 1'b0;
    ack_mode = 1'b0; ack_force = 1'b0; pipe_stall = 1'b0;
    do_reset();

    // reset state
    chk("rst_data_out", data_out, 0);
    chk("rst_done0", done0, 0);
    chk("rst_done1", done1, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);

    // single token from requester 0, ack one cycle after each data_out change
    eq0.push_back(1'b1); bit0 = 1'b1; req0 = 1'b1;
    n = 0; got = 1'b0; saw = 1'b0; cw = 0;
    while (!got && n < 100) begin
      tick(); n++;
      if (cw == 0 && data_out != 2'b00) cw = data_out;
      if (done1) saw = 1'b1;
      if (done0) got = 1'b1;
    end
    req0 = 1'b0;
    chk("t1_done0_seen", got, 1);
    chk("t1_latency", n, 2 * SYNC + 5);
    chk("t1_codeword", cw, 2);
    chk("t1_done1_never", saw, 0);
    chk("t1_err", err, 0);
    saw = 1'b0;
    repeat (10) begin tick(); if (done0 || done1) saw = 1'b1; end
    chk("t1_single_pulse", saw, 0);

    // req dropped after grant still completes
    eq1.push_back(1'b0); bit1 = 1'b0; req1 = 1'b1;
    n = 0;
    while (data_out == 2'b00 && n < 20) begin tick(); n++; end
    req1 = 1'b0;
    n = 0; got = 1'b0;
    while (!got && n < 100) begin tick(); n++; if (done1) got = 1'b1; end
    chk("t2_done1_after_drop", got, 1);
    repeat (5) tick();

    // both requesters continuously high: grants alternate 0,1,0,1
    do_reset();
    eq0.push_back(1'b0); eq0.push_back(1'b0);
    eq1.push_back(1'b1); eq1.push_back(1'b1);
    bit0 = 1'b0; bit1 = 1'b1; req0 = 1'b1; req1 = 1'b1;
    n = 0;
    while (dlog.size() < 4 && n < 300) begin
      tick(); n++;
      if (done0) dlog.push_back(0);
      if (done1) dlog.push_back(1);
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("t3_done_count", dlog.size(), 4);
    for (int i = 0; i < 4 && i < dlog.size(); i++) chk("t3_alternate", dlog[i], i % 2);
    repeat (10) tick();

    // ack stuck high while idle: no launch until it falls
    do_reset();
    ack_mode = 1'b1; ack_force = 1'b1;
    repeat (5) tick();
    b = 1'($urandom_range(0, 1));
    eq0.push_back(b); bit0 = b; req0 = 1'b1;
    stay = 1'b1;
    repeat (10) begin tick(); if (data_out != 2'b00) stay = 1'b0; end
    chk("t4_held_idle", stay, 1);
    chk("t4_busy_idle", busy, 0);
    ack_force = 1'b0; ack_mode = 1'b0;
    n = 0;
    while (data_out == 2'b00 && n < 20) begin tick(); n++; end
    chk("t4_data_codeword", data_out, b ? 2 : 1);
    n = 0; got = 1'b0;
    while (!got && n < 100) begin tick(); n++; if (done0) got = 1'b1; end
    req0 = 1'b0;
    chk("t4_done0", got, 1);

    // ack never arrives: timeout into sticky ERR
    do_reset();
    ack_mode = 1'b1; ack_force = 1'b0;
    b = 1'($urandom_range(0, 1));
    eq1.push_back(b); bit1 = b; req1 = 1'b1;
    n = 0; cnt = 0;
    while (!err && n < TO + 30) begin
      tick(); n++;
      if (!err && data_out != 2'b00) cnt++;
    end
    chk("t5_err", err, 1);
    chk("t5_data_cycles", cnt, TO);
    chk("t5_data_out", data_out, 0);
    chk("t5_busy", busy, 1);
    req1 = 1'b0; req0 = 1'b1;
    saw = 1'b0;
    repeat (20) begin tick(); if (data_out != 2'b00 || done0 || done1) saw = 1'b1; end
    chk("t5_req_ignored", saw, 0);
    chk("t5_err_sticky", err, 1);
    do_reset();
    chk("t5_err_cleared", err, 0);
    chk("t5_busy_cleared", busy, 0);
    ack_mode = 1'b0;

    // reset pulsed while in NULL: token abandoned, no done
    eq0.push_back(1'b1); bit0 = 1'b1; req0 = 1'b1;
    n = 0; saw = 1'b0; got = 1'b0;
    while (!got && n < 60) begin
      tick(); n++;
      if (saw && data_out == 2'b00 && busy) got = 1'b1;
      if (data_out != 2'b00) saw = 1'b1;
    end
    chk("t6_reached_null", got, 1);
    rst = 1'b1; req0 = 1'b0;
    tick();
    rst = 1'b0;
    chk("t6_data_out", data_out, 0);
    chk("t6_busy", busy, 0);
    chk("t6_err", err, 0);
    chk("t6_done0", done0, 0);
    chk("t6_done1", done1, 0);
    saw = 1'b0;
    repeat (15) begin tick(); if (done0 || done1 || busy) saw = 1'b1; end
    chk("t6_no_done", saw, 0);

    // random traffic against the stalling pipeline model
    do_reset();
    pipe_stall = 1'b1;
    fork
      drive(0, 25);
      drive(1, 25);
    join
    repeat (60) tick();
    chk("rand_all_delivered", gq.size(), 0);
    chk("rand_req0_drained", eq0.size(), 0);
    chk("rand_req1_drained", eq1.size(), 0);
    chk("rand_err", err, 0);
    chk("rand_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/dr_channel_arbiter.md
DR_CHANNEL_ARBITER -- requirements
Module: dr_channel_arbiter

Interface
REQ-001 The block SHALL have a parameter SYNC_STAGES, default 2: number of flops synchronising ack_in, legal range 2..4.
REQ-002 The block SHALL have a parameter TIMEOUT, default 64: maximum cycles spent waiting for any single ack edge, legal range 4..1023.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port req0, input, 1 bit: requester 0 wants to send one bit; held until done0.
REQ-006 The block SHALL have port bit0, input, 1 bit: value to send for requester 0; stable while req0 is high.
REQ-007 The block SHALL have port done0, output, 1 bit: one-cycle pulse when requester 0's token has completed a full 4-phase cycle.
REQ-008 The block SHALL have ports req1 (input), bit1 (input) and done1 (output), each 1 bit, with the same meanings for requester 1.
REQ-009 The block SHALL have port data_out, output, 2 bits: dual-rail codeword driven into the head of the async buffer pipeline; [1] is the true rail, [0] the false rail.
REQ-010 The block SHALL have port ack_in, input, 1 bit: asynchronous acknowledge (ack_ant) from the pipeline head stage.
REQ-011 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-012 The block SHALL have port err, output, 1 bit: sticky timeout flag.

Function
REQ-013 The block SHALL sample ack_in only through a SYNC_STAGES-deep flop chain; the last flop is ack_s, and no logic SHALL use ack_in directly.
REQ-014 The FSM SHALL have the states IDLE, DATA, NULL, DONE and ERR.
REQ-015 IDLE: data_out SHALL be 2'b00; if any req is high and ack_s is 0, the FSM SHALL grant one requester, latch its bit, and go to DATA on the next edge.
REQ-016 Arbitration SHALL be round-robin: when both reqs are high, the requester not granted last wins; after reset, requester 0 has priority.
REQ-017 DATA: data_out SHALL be {latched_bit, ~latched_bit} (2'b10 for 1, 2'b01 for 0); when ack_s is 1, the FSM SHALL go to NULL.
REQ-018 NULL: data_out SHALL be 2'b00; when ack_s is 0, the FSM SHALL go to DONE.
REQ-019 DONE: the block SHALL pulse done0 or done1 (the granted one) for exactly one cycle, update the last-granted pointer, and return to IDLE.
REQ-020 Latency, uncontended, with the ack returning immediately: DATA SHALL be entered 1 cycle after the req is seen, and done SHALL assert SYNC_STAGES+1 cycles after each ack edge, minimum 2*SYNC_STAGES+3 cycles from req to done.
REQ-021 data_out SHALL be driven from registers only, so that no glitch and no 2'b11 codeword ever appears; 2'b11 is illegal in every state.
REQ-022 A wait counter SHALL clear on entry to DATA and on entry to NULL, and SHALL increment every cycle spent in DATA or NULL.
REQ-023 When the wait counter reaches TIMEOUT-1, the FSM SHALL go to ERR, with no done pulse.
REQ-024 ERR: data_out SHALL be 2'b00, err SHALL be 1, busy SHALL be 1, and no grants SHALL be issued; only rst exits ERR.
REQ-025 If ack_s is 1 while in IDLE (pipeline not yet drained), the FSM SHALL stay in IDLE until ack_s is 0.
REQ-026 A req deasserted after its grant SHALL be ignored: the token in flight SHALL complete and done SHALL still pulse.
REQ-027 A requester whose done pulse coincides with its req still high SHALL be eligible again only in the following IDLE cycle, subject to round-robin.
REQ-028 The latched bit and the granted index SHALL remain constant from grant until DONE.

Reset
REQ-029 On rst=1 at a rising edge, the FSM SHALL go to IDLE, with data_out=2'b00, done0=done1=0, busy=0, err=0, wait counter=0, last-granted=1 (so requester 0 wins first), and all synchroniser flops=0.
REQ-030 Reset asserted mid-transaction SHALL abandon the token without any done pulse; the pipeline is expected to be reset in parallel.

Verification
REQ-031 The bench SHALL cover: req0=1, bit0=1, ack model responds 1 cycle after each data_out change -> data_out 00->10->00, done0 pulses once, done1 never pulses, err=0.
REQ-032 The bench SHALL cover: req0=req1=1 continuously, bit0=0, bit1=1 -> grants alternate 0,1,0,1; data_out codewords 01,10,01,10; done0 and done1 alternate.
REQ-033 The bench SHALL cover: req1=1 with ack_in held at 0 -> after TIMEOUT cycles in DATA, err=1, data_out=00, busy=1; a later req0 is ignored until rst.
REQ-034 The bench SHALL cover: ack_in held at 1 while idle, then req0 raised -> data_out stays 00 until ack_in falls, then DATA is entered.
REQ-035 The bench SHALL cover: rst pulsed while in NULL -> next cycle IDLE, all outputs at reset values, no done pulse.
REQ-036 The bench SHALL cover: random req/bit traffic against a 3-stage async buffer model -> data_out is never 2'b11, every done is preceded by exactly one DATA/NULL pair, and the delivered bit sequence equals the granted bit sequence.
